// File: rtl/inv_diffusion_layer_iter.sv
`default_nettype none
// ============================================================================
//  Module   : inv_diffusion_layer_iter
//  Purpose  : Iterative inverse of the ASCON linear diffusion layer.
//             Every row satisfies Sigma^64 = I, so Sigma^-1 = Sigma^63, which
//             is the product of Sigma^(2^k) for k = 0..5. Step k is
//             x ^ ror(x, a*2^k mod 64) ^ ror(x, b*2^k mod 64).
//             STEPS_PER_CYCLE steps are applied per clock to all five rows.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_diffusion_layer_iter #(
   parameter int STEPS_PER_CYCLE = 1   // 1, 2, 3 or 6
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [4:0][63:0] state_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [4:0][63:0] state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] C_SPC       = 4'(STEPS_PER_CYCLE);
   localparam logic [3:0] C_NUM_STEPS = 4'd6;

   // Forward rotation pairs (a, b) for rows 0..4.
   localparam logic [5:0] C_ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
   localparam logic [5:0] C_ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

   // Rotate right; the doubled word makes a rotation by 0 fall out naturally.
   function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
      logic [127:0] t;
      t = {x, x} >> n;
      return t[63:0];
   endfunction

   // One Sigma^(2^k) step on a row. The 6-bit shift wraps the amount mod 64.
   // Step indices beyond 5 never occur in legal operation and pass through.
   function automatic logic [63:0] sigma_pow(input logic [63:0] x, input int row,
                                             input logic [2:0] k);
      logic [5:0] a;
      logic [5:0] b;
      a = C_ROT_A[row] << k;
      b = C_ROT_B[row] << k;
      if (k > 3'd5) begin
         return x;
      end
      return x ^ ror64(x, a) ^ ror64(x, b);
   endfunction

   logic [1:0]       fsm_q, fsm_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [4:0][63:0] work_q, work_d;
   logic [4:0][63:0] out_q, out_d;
   logic [4:0][63:0] work_step;
   logic [3:0]       cnt_sum;

   // Apply this cycle's batch of steps, ascending k, to all rows.
   always_comb begin
      work_step = work_q;
      for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
         for (int r = 0; r < 5; r++) begin
            work_step[r] = sigma_pow(work_step[r], r, cnt_q + 3'(j));
         end
      end
   end

   assign cnt_sum = {1'b0, cnt_q} + C_SPC;

   // Next-state logic: load in IDLE, iterate in RUN, hold result in DONE.
   always_comb begin
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      work_d = work_q;
      out_d  = out_q;
      case (fsm_q)
         S_IDLE: begin
            if (valid_i) begin
               work_d = state_i;
               cnt_d  = 3'd0;
               fsm_d  = S_RUN;
            end
         end
         S_RUN: begin
            if ({1'b0, cnt_q} >= C_NUM_STEPS) begin
               // Corrupted counter: abandon the operation.
               fsm_d = S_IDLE;
               cnt_d = 3'd0;
            end else begin
               work_d = work_step;
               cnt_d  = cnt_sum[2:0];
               if (cnt_sum >= C_NUM_STEPS) begin
                  fsm_d = S_DONE;
                  out_d = work_step;
               end
            end
         end
         S_DONE: begin
            if (ready_i) begin
               fsm_d = S_IDLE;
               cnt_d = 3'd0;
            end
         end
         default: begin
            fsm_d = S_IDLE;
            cnt_d = 3'd0;
         end
      endcase
   end

   // State registers with asynchronous clear; a pending result is discarded.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         fsm_q  <= S_IDLE;
         cnt_q  <= 3'd0;
         work_q <= '0;
         out_q  <= '0;
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         work_q <= work_d;
         out_q  <= out_d;
      end
   end

   // ready_o is forced low for as long as reset is held.
   assign ready_o = (fsm_q == S_IDLE) && !reset_i;
   assign valid_o = (fsm_q == S_DONE);
   assign state_o = out_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_diffusion_layer_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_diffusion_layer_iter
//  Purpose  : Bench for inv_diffusion_layer_iter with STEPS_PER_CYCLE 1,2,3,6.
//             Reference inverse is Sigma applied 63 times per row.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_diffusion_layer_iter;

   typedef logic [4:0][63:0] st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic v_i   [4];
   logic rdy_o [4];
   logic v_o   [4];
   logic rdy_i [4];
   st_t  s_i   [4];
   st_t  s_o   [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      inv_diffusion_layer_iter #(
         .STEPS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6)
      ) u_dut (
         .clock_i (clk),
         .reset_i (rst),
         .valid_i (v_i[g]),
         .ready_o (rdy_o[g]),
         .state_i (s_i[g]),
         .valid_o (v_o[g]),
         .ready_i (rdy_i[g]),
         .state_o (s_o[g])
      );
   end

   int n_cmp = 0;
   int n_err = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int RA  [5] = '{19, 61, 1, 10, 7};
   int RB  [5] = '{28, 39, 6, 17, 41};
   int LAT [4] = '{6, 3, 2, 1};

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      if (n == 0) return x;
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] fwd_row(input logic [63:0] x, input int r);
      return x ^ rotr(x, RA[r]) ^ rotr(x, RB[r]);
   endfunction

   function automatic st_t fwd(input st_t s);
      st_t o;
      for (int r = 0; r < 5; r++) o[r] = fwd_row(s[r], r);
      return o;
   endfunction

   function automatic st_t inv_model(input st_t s);
      st_t o;
      for (int r = 0; r < 5; r++) begin
         logic [63:0] y;
         y = s[r];
         for (int i = 0; i < 63; i++) y = fwd_row(y, r);
         o[r] = y;
      end
      return o;
   endfunction

   task automatic chk(input string name, input st_t got, input st_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout waiting for DUT", name);
   endtask

   // Model state for each DUT.
   bit          busy [4];
   int unsigned acc  [4];
   st_t         expv [4];
   st_t         last [4];

   // Compare process: every cycle, check all DUTs against the model.
   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (rst) begin
            chk($sformatf("rst_valid_o[%0d]", d), st_t'(v_o[d]), '0);
            chk($sformatf("rst_ready_o[%0d]", d), st_t'(rdy_o[d]), '0);
            chk($sformatf("rst_state_o[%0d]", d), s_o[d], '0);
            busy[d] = 1'b0;
            last[d] = '0;
         end else begin
            bit mv;
            mv = busy[d] && (cyc >= acc[d] + LAT[d]);
            chk($sformatf("valid_o[%0d]", d), st_t'(v_o[d]), st_t'(mv));
            chk($sformatf("ready_o[%0d]", d), st_t'(rdy_o[d]), st_t'(!busy[d]));
            chk($sformatf("state_o[%0d]", d), s_o[d], mv ? expv[d] : last[d]);
            if (mv && rdy_i[d]) begin
               busy[d] = 1'b0;
               last[d] = expv[d];
            end else if (!busy[d] && v_i[d]) begin
               busy[d] = 1'b1;
               acc[d]  = cyc + 1;
               expv[d] = inv_model(s_i[d]);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int d, input st_t st);
      int n;
      n = 0;
      while (!rdy_o[d] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) timeout("send");
      v_i[d] = 1'b1;
      s_i[d] = st;
      @(posedge clk); #1;
      v_i[d] = 1'b0;
      s_i[d] = ~st;
   endtask

   task automatic wait_valid(input int d, output st_t got);
      int n;
      n = 0;
      while (!v_o[d] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) timeout("wait_valid");
      got = s_o[d];
   endtask

   task automatic xfer(input int d, input st_t st, input st_t lit, input string name);
      st_t got;
      send(d, st);
      wait_valid(d, got);
      chk(name, got, lit);
      @(posedge clk); #1;
   endtask

   initial begin
      st_t rt, ones, got, st;
      rt[0] = 64'h78e2cc41faabaa1a;
      rt[1] = 64'hbc7a2e775aababf7;
      rt[2] = 64'h4b81c0cbbdb5fc1a;
      rt[3] = 64'hb22e133e424f0250;
      rt[4] = 64'h044d33702433805d;
      ones = '1;
      for (int d = 0; d < 4; d++) begin
         v_i[d] = 1'b0; rdy_i[d] = 1'b1; s_i[d] = '0;
      end

      // Reset state, then release.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state_o", s_o[0], '0);
      chk("reset_valid_o", st_t'(v_o[0]), '0);
      chk("reset_ready_o", st_t'(rdy_o[0]), '0);
      rst = 1'b0;
      #1;
      chk("release_ready_o", st_t'(rdy_o[0]), st_t'(1'b1));
      @(posedge clk); #1;

      // Pin the reference model with hand-derived values.
      chk("pin_fwd_row2", st_t'(fwd_row(64'h1, 2)), st_t'(64'h8400000000000001));
      chk("pin_fwd_row0", st_t'(fwd_row(64'h1, 0)), st_t'(64'h0000201000000001));
      chk("pin_inv_roundtrip", inv_model(fwd(rt)), rt);

      // Round trip and fixed points.
      xfer(0, fwd(rt), rt, "roundtrip");
      xfer(0, '0, '0, "zeros");
      xfer(0, ones, ones, "ones");

      // Single-bit sweep on every STEPS_PER_CYCLE variant.
      for (int d = 0; d < 4; d++) begin
         for (int i = 0; i < ((d == 0) ? 50 : 12); i++) begin
            int r, j;
            r = int'($urandom_range(4, 0));
            j = int'($urandom_range(63, 0));
            st = '0;
            st[r][j] = 1'b1;
            xfer(d, fwd(st), st, "sweep");
         end
      end
      xfer(3, fwd(rt), rt, "roundtrip_spc6");

      // Backpressure: result must hold for 10 cycles.
      rdy_i[0] = 1'b0;
      send(0, fwd(ones ^ rt));
      wait_valid(0, got);
      chk("bp_result", got, ones ^ rt);
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("bp_held", s_o[0], ones ^ rt);
      chk("bp_ready_low", st_t'(rdy_o[0]), '0);
      rdy_i[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", st_t'(v_o[0]), '0);
      chk("bp_release_ready", st_t'(rdy_o[0]), st_t'(1'b1));

      // Busy input is ignored.
      send(0, fwd(rt));
      v_i[0] = 1'b1;
      s_i[0] = fwd(ones ^ rt);
      repeat (2) begin
         @(posedge clk); #1;
      end
      v_i[0] = 1'b0;
      wait_valid(0, got);
      chk("busy_ignored", got, rt);
      @(posedge clk); #1;

      // Reset in the middle of RUN.
      send(0, fwd(ones ^ rt));
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_state_o", s_o[0], '0);
      chk("midrst_valid_o", st_t'(v_o[0]), '0);
      chk("midrst_ready_o", st_t'(rdy_o[0]), '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      st = '0;
      st[1] = 64'h0123456789abcdef;
      st[4] = 64'hfedcba9876543210;
      xfer(0, fwd(st), st, "after_reset");

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
